hazard_fwd_ctrl: RTL

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : Pipeline hazard detection, operand forwarding select and
//            stall/flush control with a saturating stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_rd,
  input  logic             id_rs2_rd,
  input  logic [AW-1:0]    ex_rd,
  input  logic [AW-1:0]    mem_rd,
  input  logic [AW-1:0]    wb_rd,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic             ex_is_load,
  input  logic             branch_taken,
  input  logic             clr_cnt,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       m1_ex, m1_mem, m1_wb;
  logic       m2_ex, m2_mem, m2_wb;
  logic [1:0] fwd_rs1_raw, fwd_rs2_raw;
  logic [1:0] depth;
  logic       stall;

  // Priority encode a forwarding source: nearest producer wins.
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb);
    logic [1:0] s;
    s = 2'b00;
    if (m_ex)       s = 2'b01;
    else if (m_mem) s = 2'b10;
    else if (m_wb)  s = 2'b11;
    return s;
  endfunction

  // Source/destination match per stage; register x0 is never a dependency.
  always_comb begin
    m1_ex  = id_rs1_rd & ex_we  & (ex_rd  == id_rs1) & (id_rs1 != '0);
    m1_mem = id_rs1_rd & mem_we & (mem_rd == id_rs1) & (id_rs1 != '0);
    m1_wb  = id_rs1_rd & wb_we  & (wb_rd  == id_rs1) & (id_rs1 != '0);
    m2_ex  = id_rs2_rd & ex_we  & (ex_rd  == id_rs2) & (id_rs2 != '0);
    m2_mem = id_rs2_rd & mem_we & (mem_rd == id_rs2) & (id_rs2 != '0);
    m2_wb  = id_rs2_rd & wb_we  & (wb_rd  == id_rs2) & (id_rs2 != '0);
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Forwarding mode: only a load in EX cannot be bypassed (one-cycle hazard).
      always_comb begin
        fwd_rs1_raw = fwd_sel(m1_ex & ~ex_is_load, m1_mem, m1_wb);
        fwd_rs2_raw = fwd_sel(m2_ex & ~ex_is_load, m2_mem, m2_wb);
        depth       = (ex_is_load & (m1_ex | m2_ex)) ? 2'd1 : 2'd0;
      end
    end else begin : g_stall
      // Stall-only mode: wait until the producer has written the register file.
      always_comb begin
        fwd_rs1_raw = 2'b00;
        fwd_rs2_raw = 2'b00;
        depth       = 2'd0;
        if (m1_ex | m2_ex)        depth = 2'd3;
        else if (m1_mem | m2_mem) depth = 2'd2;
        else if (m1_wb | m2_wb)   depth = 2'd1;
      end
    end
  endgenerate

  // Stall FSM next state: branch redirect overrides, HOLD ignores new hazards.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    if (branch_taken) begin
      state_d = IDLE;
      rem_d   = 2'd0;
    end else if (state_q == HOLD) begin
      stall = 1'b1;
      rem_d = rem_q - 2'd1;
      if (rem_q == 2'd1) begin
        state_d = IDLE;
      end
    end else if (depth != 2'd0) begin
      stall = 1'b1;
      if (depth > 2'd1) begin
        state_d = HOLD;
        rem_d   = depth - 2'd1;
      end else begin
        rem_d = 2'd0;
      end
    end
  end

  // Stall counter next value: clear wins, otherwise saturating increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, remaining-stall count and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are gated by reset so they drop immediately, without a clock.
  always_comb begin
    stall_if    = rst_n & stall;
    stall_id    = rst_n & stall;
    flush_id    = rst_n & branch_taken;
    flush_ex    = rst_n & (stall | branch_taken);
    fwd_rs1_sel = rst_n ? fwd_rs1_raw : 2'b00;
    fwd_rs2_sel = rst_n ? fwd_rs2_raw : 2'b00;
    stall_cnt   = stall_cnt_q;
  end

endmodule
`default_nettype wire
